// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: FSM states, ACK/NACK bit values
// and the default device address and register-file size.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1D;
    localparam int         DEFAULT_NUM_REGS = 64;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings raw SCL/SDA into the clk domain and derives SCL edge strobes plus
// START/STOP conditions from the synchronized levels.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    // Bit 0: metastability stage, bit 1: synchronized level, bit 2: previous level.
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;
    logic       scl_s, scl_p, sda_p;

    // Next value of each pipeline is the pipeline shifted by one with the pad sample.
    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl};
        sda_pipe_d = {sda_pipe_q[1:0], sda_in};
    end

    // Pipelines reset to the idle-bus level (both lines high) so that leaving
    // reset never fabricates an edge or a START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_pipe_q <= '1;
            sda_pipe_q <= '1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old value of its
            // neighbour, which is exactly what a shift-register synchronizer needs.
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end

    assign scl_s     = scl_pipe_q[1];
    assign scl_p     = scl_pipe_q[2];
    assign sda_s     = sda_pipe_q[1];
    assign sda_p     = sda_pipe_q[2];

    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & sda_p & ~sda_s;
    assign stop_det  = scl_s & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a byte-wide register file: pointer write, burst write and
// burst read with pointer auto-increment, plus a local host port.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter int         NUM_REGS = DEFAULT_NUM_REGS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       bus_wr_pulse,
    output logic [7:0] bus_wr_addr,
    output logic [7:0] bus_wr_data
);

    localparam int PW = $clog2(NUM_REGS);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          ack_ok_q, ack_ok_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];

    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;
    logic          byte_done;
    logic          bus_we;
    logic [PW-1:0] host_idx;
    logic          unused_host_bits;

    assign host_idx         = host_addr[PW-1:0];
    assign unused_host_bits = ^host_addr;
    assign rd_byte          = regs_q[ptr_q];

    // Next-state and datapath decode; START/STOP override whatever the FSM is doing.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        ack_ok_d   = ack_ok_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        bus_we     = 1'b0;
        rx_byte    = {shift_q[6:0], sda_s};
        byte_done  = scl_rise && (cnt_q == 3'd7);

        if (stop_det) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
        end else if (start_det) begin
            state_d  = ST_ADDR;
            busy_d   = 1'b1;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_WAIT_STOP: sda_oe_d = 1'b0;

                ST_ADDR: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (byte_done) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            rw_d    = rx_byte[0];
                            state_d = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end

                // ACK slots: the first scl_fall pulls SDA low, the second ends the slot.
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (rw_q) begin
                        shift_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        state_d  = ST_RD_DATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_PTR;
                    end
                end

                ST_PTR: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (byte_done) begin
                        ptr_d   = rx_byte[PW-1:0];
                        state_d = ST_PTR_ACK;
                    end
                end

                ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_DATA;
                    end
                end

                ST_WR_DATA: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (byte_done) begin
                        bus_we     = 1'b1;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = 8'(ptr_q);
                        wr_data_d  = rx_byte;
                        ptr_d      = ptr_q + PW'(1);
                        state_d    = ST_WR_ACK;
                    end
                end

                ST_RD_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d   = cnt_q + 3'd1;
                        if (byte_done) begin
                            ptr_d    = ptr_q + PW'(1);
                            ack_ok_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~shift_q[7];
                    end
                end

                // First scl_fall releases SDA for the initiator; its ACK is sampled on
                // the rise and the following fall starts the next byte from a fresh snapshot.
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) ack_ok_d = 1'b1;
                        else                  state_d  = ST_WAIT_STOP;
                    end else if (scl_fall) begin
                        if (!ack_ok_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            ack_ok_d = 1'b0;
                            state_d  = ST_RD_DATA;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Register-file next value: the bus write is applied last so it wins a same-index clash.
    always_comb begin
        regs_d = regs_q;
        if (host_we) regs_d[host_idx] = host_wdata;
        if (bus_we)  regs_d[ptr_q]    = rx_byte;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Control and datapath registers; asynchronous reset releases SDA at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            ack_ok_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            ack_ok_q   <= ack_ok_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Register file storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this array is deliberately built from resettable flops rather than RAM,
            // because the registers must read back as zero straight after reset.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign host_rdata   = regs_q[host_idx];
    assign bus_wr_pulse = wr_pulse_q;
    assign bus_wr_addr  = wr_addr_q;
    assign bus_wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: an I2C initiator agent drives the bus,
// a transaction-level register model predicts ACKs, read bytes and write
// pulses, and monitor processes compare DUT behaviour against those queues.
module tb_i2c_target;

    localparam int         NREG = 64;
    localparam logic [6:0] DEV  = 7'h1D;
    localparam int         Q    = 50;    // quarter SCL period; SCL period is 20 clk

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic [7:0] host_rdata;
    logic       bus_wr_pulse;
    logic [7:0] bus_wr_addr, bus_wr_data;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target #(.DEV_ADDR(DEV), .NUM_REGS(NREG)) dut (
        .clk          (clk),
        .rst          (rst),
        .scl          (scl_m),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .busy         (busy),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .bus_wr_pulse (bus_wr_pulse),
        .bus_wr_addr  (bus_wr_addr),
        .bus_wr_data  (bus_wr_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register contents and pointer, updated per transaction.
    logic [7:0] mregs [NREG];
    int         mptr = 0;

    // Scoreboard queues.
    string       exp_name_q [$];
    logic [7:0]  exp_val_q  [$];
    logic [7:0]  obs_q      [$];
    logic [15:0] wr_exp_q   [$];

    logic [7:0] wbuf [8];
    int         oe_rises = 0;
    bit         hm_en = 1'b0;
    logic [7:0] hm_addr, hm_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_bus(input string name, input logic [7:0] v);
        exp_name_q.push_back(name);
        exp_val_q.push_back(v);
    endtask

    // Monitor: bus responses observed by the agent against predicted ones.
    initial forever begin
        logic [7:0] ob;
        @(negedge clk);
        while (obs_q.size() > 0) begin
            ob = obs_q.pop_front();
            if (exp_val_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL bus_unexpected: got %0h, expected no response", ob);
            end else begin
                check(exp_name_q.pop_front(), ob, exp_val_q.pop_front());
            end
        end
    end

    // Monitor: every write pulse must match the next predicted commit.
    initial forever begin
        logic [15:0] e;
        @(negedge clk);
        if (rst && bus_wr_pulse) begin
            if (wr_exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL wr_pulse_unexpected: got addr %0h data %0h, expected no pulse",
                         bus_wr_addr, bus_wr_data);
            end else begin
                e = wr_exp_q.pop_front();
                check("wr_addr", bus_wr_addr, e[15:8]);
                check("wr_data", bus_wr_data, e[7:0]);
            end
        end
    end

    // SDA drive may only change while SCL is low.
    initial forever begin
        @(sda_oe);
        if (rst) check("oe_change_scl_low", scl_m, 1'b0);
    end

    initial forever begin
        @(posedge sda_oe);
        oe_rises++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus agent ----------------
    task automatic bus_bit(input logic b, output logic r);
        #(Q); sda_m = b; #(Q); scl_m = 1'b1; #(Q); r = sda_line; #(Q); scl_m = 1'b0;
    endtask

    task automatic send_start;
        @(negedge clk);
        #(Q); sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b0; #(Q); scl_m = 1'b0;
    endtask

    task automatic send_stop_chk;
        #(Q); sda_m = 1'b0; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b1; #(2*Q);
        check("busy_after_stop", busy, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, r);
        obs_q.push_back({7'd0, r});
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        mregs[int'(a) % NREG] = d;
    endtask

    task automatic read_byte(input logic do_ack, input bit pk, input int pa, input logic [7:0] pv);
        logic r;
        logic [7:0] v;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            v[i] = r;
            if (pk && i == 5) host_write(8'(pa), pv);
        end
        bus_bit(do_ack ? 1'b0 : 1'b1, r);
        obs_q.push_back(v);
    endtask

    task automatic hammer_run;
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 1'b0;
        if (hm_en) begin
            while (!seen && cyc < 400) begin
                @(negedge clk);
                if (bus_wr_pulse) seen = 1'b1;
                else begin host_we = 1'b1; host_addr = hm_addr; host_wdata = hm_data; end
                cyc++;
            end
            host_we = 1'b0;
            check("hammer_pulse_seen", seen, 1'b1);
            hm_en = 1'b0;
        end
    endtask

    // ---------------- transactions + model ----------------
    task automatic txn_write(input logic [6:0] a, input logic [7:0] p, input int n, input bit do_stop);
        logic hit;
        bit   hm;
        hit = (a == DEV);
        send_start;
        check("busy_after_start", busy, 1'b1);
        expect_bus("addr_ack", hit ? 8'h00 : 8'h01);
        send_byte({a, 1'b0});
        if (hit) mptr = int'(p) % NREG;
        expect_bus("ptr_ack", hit ? 8'h00 : 8'h01);
        send_byte(p);
        for (int i = 0; i < n; i++) begin
            hm = hm_en;
            if (hit) begin
                if (hm) mregs[int'(hm_addr) % NREG] = hm_data;
                wr_exp_q.push_back({8'(mptr), wbuf[i]});
                mregs[mptr] = wbuf[i];
                mptr = (mptr + 1) % NREG;
            end
            expect_bus("data_ack", hit ? 8'h00 : 8'h01);
            fork
                send_byte(wbuf[i]);
                hammer_run();
            join
        end
        if (do_stop) begin
            check("busy_before_stop", busy, 1'b1);
            send_stop_chk();
        end
    endtask

    task automatic txn_read(input int n, input bit poke);
        logic [7:0] pv;
        send_start;
        check("busy_after_start", busy, 1'b1);
        expect_bus("rd_addr_ack", 8'h00);
        send_byte({DEV, 1'b1});
        for (int i = 0; i < n; i++) begin
            expect_bus("rd_data", mregs[mptr]);
            pv = 8'($urandom);
            read_byte(i != n - 1, poke && i == 0, mptr, pv);
            mptr = (mptr + 1) % NREG;
        end
        check("busy_before_stop", busy, 1'b1);
        send_stop_chk();
    endtask

    task automatic check_regs;
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            host_addr = {2'($urandom), 6'(i)};
            #1;
            check($sformatf("reg[%0h]", i), host_rdata, mregs[i]);
        end
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         c0;
        logic       r;
        logic [7:0] abyte;
        int         kind, n;
        logic [6:0] bad;

        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        #1;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pulse", bus_wr_pulse, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single write to 0x2D.
        wbuf[0] = 8'h08;
        txn_write(DEV, 8'h2D, 1, 1'b1);

        // Wrong address: no ACK, no commit.
        c0 = oe_rises;
        wbuf[0] = 8'h77;
        txn_write(7'h53, 8'h00, 1, 1'b1);
        check("nomatch_no_oe", oe_rises - c0, 0);

        // Pointer write, repeated start, burst read; then current-address read.
        host_write(8'h32, 8'hA5);
        host_write(8'h33, 8'h5A);
        host_write(8'h34, 8'hC3);
        txn_write(DEV, 8'h32, 0, 1'b0);
        txn_read(2, 1'b0);
        txn_read(1, 1'b0);

        // Pointer wrap.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        txn_write(DEV, 8'h3F, 2, 1'b1);

        // Bus write and host write to the same register in the commit cycle.
        hm_en = 1'b1; hm_addr = 8'h45; hm_data = 8'hEE;  // 0x45 aliases register 0x05
        wbuf[0] = 8'h9C;
        txn_write(DEV, 8'h05, 1, 1'b1);
        // And to a different register.
        hm_en = 1'b1; hm_addr = 8'h10; hm_data = 8'h4B;
        wbuf[0] = 8'h3D;
        txn_write(DEV, 8'h06, 1, 1'b1);

        // Host overwrites the register being read mid-byte.
        txn_write(DEV, 8'h32, 0, 1'b0);
        txn_read(2, 1'b1);
        check_regs();

        // STOP after four bits of a data byte, then a normal transaction.
        txn_write(DEV, 8'h20, 0, 1'b0);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), r);
        send_stop_chk();
        txn_read(1, 1'b0);
        wbuf[0] = 8'h5E;
        txn_write(DEV, 8'h21, 1, 1'b1);
        check_regs();

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 4));
            n    = int'($urandom_range(1, 3));
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            case (kind)
                0: txn_write(DEV, 8'($urandom), n, 1'b1);
                1: begin txn_write(DEV, 8'($urandom), 0, 1'b0); txn_read(n, 1'b0); end
                2: txn_read(n, 1'($urandom));
                3: begin
                    bad = 7'($urandom);
                    if (bad == DEV) bad = 7'h1C;
                    txn_write(bad, 8'($urandom), n, 1'b1);
                end
                default: host_write(8'($urandom), 8'($urandom));
            endcase
        end
        check_regs();

        // Reset asserted while the target is driving the address ACK.
        send_start;
        abyte = {DEV, 1'b0};
        for (int i = 7; i >= 0; i--) bus_bit(abyte[i], r);
        #(Q);
        check("ack_driven_before_rst", sda_oe, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_mid_oe", sda_oe, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_pulse", bus_wr_pulse, 1'b0);
        check("rst_mid_wr_addr", bus_wr_addr, 8'h00);
        check("rst_mid_wr_data", bus_wr_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        mptr = 0;
        send_stop_chk();
        check_regs();
        txn_read(1, 1'b0);

        repeat (10) @(negedge clk);
        check("bus_exp_left", exp_val_q.size(), 0);
        check("wr_exp_left", wr_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
